// File: rtl/time_counter.sv
// ---------------------------------------------------------------------------
// time_counter -- 24-hour time-of-day counter with a CLK_FREQ prescaler.
//
// A prescaler divides clk down to a once-per-second tick.  Each tick advances
// sec/min/hour with carries (23:59:59 -> 00:00:00 in one tick).  A load
// request overwrites hour/min, clears sec and restarts the second.  Out-of-
// range load values are stored as 0.
//
// Optional feature macro: HOURLY_CHIME_EN
//   defined   -> chime pulses with sec_tick on a counted xx:59:59 -> yy:00:00
//   undefined -> chime is tied to 0 and no chime logic exists
//
// Parameters:
//   CLK_FREQ       clk cycles per second (>= 2)
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   time_count_en  1 = time runs, 0 = frozen (prescaler held at 0)
//   load_en        overwrite hour/min on this edge (wins over a tick)
//   load_hour      hour to load (values > 23 load as 0)
//   load_min       minute to load (values > 59 load as 0)
//   hour/min/sec   registered current time
//   sec_tick       one-cycle pulse, coincident with the updated sec
//   chime          one-cycle pulse on a counted hour rollover (see macro)
// ---------------------------------------------------------------------------
module time_counter #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       time_count_en,
  input  logic       load_en,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_tick,
  output logic       chime
);

  localparam int              PW        = $clog2(CLK_FREQ);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          sec_wrap;
  logic          min_wrap;

  function automatic logic [4:0] clamp_hour(input logic [4:0] h);
    return (h > 5'd23) ? 5'd0 : h;
  endfunction

  function automatic logic [5:0] clamp_min(input logic [5:0] m);
    return (m > 6'd59) ? 6'd0 : m;
  endfunction

  assign tick     = time_count_en && (presc == PRESC_MAX);
  assign sec_wrap = (sec == 6'd59);
  assign min_wrap = (min == 6'd59);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= '0;
      hour     <= 5'd0;
      min      <= 6'd0;
      sec      <= 6'd0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      if (load_en) begin
        // A load restarts the second; any coincident tick is dropped.
        presc <= '0;
        hour  <= clamp_hour(load_hour);
        min   <= clamp_min(load_min);
        sec   <= 6'd0;
      end else if (!time_count_en) begin
        presc <= '0;
      end else if (tick) begin
        presc    <= '0;
        sec_tick <= 1'b1;
        if (sec_wrap) begin
          sec <= 6'd0;
          if (min_wrap) begin
            min  <= 6'd0;
            hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          end else begin
            min <= min + 6'd1;
          end
        end else begin
          sec <= sec + 6'd1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

`ifdef HOURLY_CHIME_EN
  // Counted hour rollover only: loads never chime.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chime <= 1'b0;
    end else begin
      chime <= !load_en && tick && sec_wrap && min_wrap;
    end
  end
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// ---------------------------------------------------------------------------
// tb_time_counter -- self-checking bench for time_counter (CLK_FREQ = 4).
// The reference model keeps time as seconds-of-day plus a cycle phase.
// ---------------------------------------------------------------------------
module tb_time_counter;

  localparam int CF = 4;
`ifdef HOURLY_CHIME_EN
  localparam bit CHIME_ON = 1'b1;
`else
  localparam bit CHIME_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       time_count_en;
  logic       load_en;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       sec_tick;
  logic       chime;

  time_counter #(.CLK_FREQ(CF)) dut (
    .clk          (clk),
    .rst          (rst),
    .time_count_en(time_count_en),
    .load_en      (load_en),
    .load_hour    (load_hour),
    .load_min     (load_min),
    .hour         (hour),
    .min          (min),
    .sec          (sec),
    .sec_tick     (sec_tick),
    .chime        (chime)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_t     = 0;   // seconds since midnight
  int m_phase = 0;   // cycles elapsed in the current second
  bit m_tick  = 0;
  bit m_chime = 0;

  typedef struct {
    bit         en;
    bit         ld;
    logic [4:0] lh;
    logic [5:0] lm;
    int         n;
    int         eh;
    int         em;
    int         es;
    bit         etick;
    bit         echime;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_phase = 0; m_tick = 0; m_chime = 0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input int lh, input int lm);
    m_tick  = 0;
    m_chime = 0;
    if (ld) begin
      m_t     = ((lh > 23) ? 0 : lh) * 3600 + ((lm > 59) ? 0 : lm) * 60;
      m_phase = 0;
    end else if (!en) begin
      m_phase = 0;
    end else if (m_phase == CF - 1) begin
      m_phase = 0;
      m_t     = (m_t + 1) % 86400;
      m_tick  = 1;
      m_chime = CHIME_ON && (m_t % 3600 == 0);
    end else begin
      m_phase++;
    end
  endtask

  task automatic step(input bit en, input bit ld, input logic [4:0] lh, input logic [5:0] lm);
    time_count_en = en;
    load_en       = ld;
    load_hour     = lh;
    load_min      = lm;
    @(posedge clk);
    model_edge(en, ld, int'(lh), int'(lm));
    #1;
    chk("hour",     int'(hour),     m_t / 3600);
    chk("min",      int'(min),      (m_t / 60) % 60);
    chk("sec",      int'(sec),      m_t % 60);
    chk("sec_tick", int'(sec_tick), int'(m_tick));
    chk("chime",    int'(chime),    int'(m_chime));
  endtask

  initial begin
    rst = 1'b0; time_count_en = 1'b0; load_en = 1'b0;
    load_hour = '0; load_min = '0;
    model_reset();

    //        en ld  lh     lm     n    h   m   s  tick chime
    vecs[0]  = '{1, 0, 5'd0,  6'd0,  16,  0,  0,  4, 1, 0};
    vecs[1]  = '{0, 1, 5'd30, 6'd61, 1,   0,  0,  0, 0, 0};
    vecs[2]  = '{0, 1, 5'd10, 6'd20, 1,   10, 20, 0, 0, 0};
    vecs[3]  = '{1, 0, 5'd0,  6'd0,  120, 10, 20, 30, 1, 0};
    vecs[4]  = '{0, 0, 5'd0,  6'd0,  20,  10, 20, 30, 0, 0};
    vecs[5]  = '{1, 0, 5'd0,  6'd0,  3,   10, 20, 30, 0, 0};
    vecs[6]  = '{1, 0, 5'd0,  6'd0,  1,   10, 20, 31, 1, 0};
    vecs[7]  = '{1, 1, 5'd23, 6'd59, 1,   23, 59, 0, 0, 0};
    vecs[8]  = '{1, 0, 5'd0,  6'd0,  236, 23, 59, 59, 1, 0};
    vecs[9]  = '{1, 0, 5'd0,  6'd0,  4,   0,  0,  0, 1, CHIME_ON};
    vecs[10] = '{0, 1, 5'd23, 6'd60, 1,   23, 0,  0, 0, 0};
    vecs[11] = '{0, 1, 5'd24, 6'd59, 1,   0,  59, 0, 0, 0};

    // Reset state, no clock edge needed
    #12;
    chk("rst_hour", int'(hour), 0);
    chk("rst_min",  int'(min),  0);
    chk("rst_sec",  int'(sec),  0);
    chk("rst_tick", int'(sec_tick), 0);
    chk("rst_chime", int'(chime), 0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors
    for (int v = 0; v < 12; v++) begin
      for (int c = 0; c < vecs[v].n; c++) step(vecs[v].en, vecs[v].ld, vecs[v].lh, vecs[v].lm);
      chk($sformatf("vec%0d_hour", v),  int'(hour),     vecs[v].eh);
      chk($sformatf("vec%0d_min", v),   int'(min),      vecs[v].em);
      chk($sformatf("vec%0d_sec", v),   int'(sec),      vecs[v].es);
      chk($sformatf("vec%0d_tick", v),  int'(sec_tick), int'(vecs[v].etick));
      chk($sformatf("vec%0d_chime", v), int'(chime),    int'(vecs[v].echime));
    end

    // Load coincident with a tick: tick discarded, next second is full length
    for (int c = 0; c < 3; c++) step(1, 0, 5'd0, 6'd0);
    step(1, 1, 5'd5, 6'd6);
    chk("coinc_hour", int'(hour), 5);
    chk("coinc_min",  int'(min),  6);
    chk("coinc_sec",  int'(sec),  0);
    chk("coinc_tick", int'(sec_tick), 0);
    chk("coinc_chime", int'(chime), 0);
    for (int c = 0; c < 3; c++) begin
      step(1, 0, 5'd0, 6'd0);
      chk("coinc_wait_tick", int'(sec_tick), 0);
    end
    step(1, 0, 5'd0, 6'd0);
    chk("coinc_next_tick", int'(sec_tick), 1);
    chk("coinc_next_sec",  int'(sec), 1);

    // Held load: reloads every cycle, no counting
    for (int c = 0; c < 6; c++) begin
      step(1, 1, 5'd7, 6'd8);
      chk("hold_sec",  int'(sec), 0);
      chk("hold_tick", int'(sec_tick), 0);
    end

    // Asynchronous reset mid-second at 12:34:56
    step(1, 1, 5'd12, 6'd34);
    for (int c = 0; c < 56 * CF + 2; c++) step(1, 0, 5'd0, 6'd0);
    chk("pre_rst_hour", int'(hour), 12);
    chk("pre_rst_min",  int'(min),  34);
    chk("pre_rst_sec",  int'(sec),  56);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_hour", int'(hour), 0);
    chk("async_min",  int'(min),  0);
    chk("async_sec",  int'(sec),  0);
    chk("async_tick", int'(sec_tick), 0);
    chk("async_chime", int'(chime), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < CF - 1; c++) begin
      step(1, 0, 5'd0, 6'd0);
      chk("post_rst_wait", int'(sec_tick), 0);
    end
    step(1, 0, 5'd0, 6'd0);
    chk("post_rst_tick", int'(sec_tick), 1);
    chk("post_rst_sec",  int'(sec), 1);

    // Randomized stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      bit         en, ld;
      logic [4:0] lh;
      logic [5:0] lm;
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 40) == 0);
      lh = 5'($urandom_range(0, 31));
      lm = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) begin
        lh = 5'($urandom_range(22, 24));
        lm = 6'd59;
      end
      step(en, ld, lh, lm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning clk cycles per second (legal range >= 2).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port time_count_en  input  1  1 = timekeeping runs; 0 = time frozen (adjust mode).
REQ-005 The block SHALL have port load_en  input  1  single-cycle request to overwrite hour/minute.
REQ-006 The block SHALL have port load_hour  input  5  hour value applied on load_en.
REQ-007 The block SHALL have port load_min  input  6  minute value applied on load_en.
REQ-008 The block SHALL have port hour  output  5  current hour, 0..23, registered.
REQ-009 The block SHALL have port min  output  6  current minute, 0..59, registered.
REQ-010 The block SHALL have port sec  output  6  current second, 0..59, registered.
REQ-011 The block SHALL have port sec_tick  output  1  one-cycle pulse, registered, on every counted second.
REQ-012 The block SHALL have port chime  output  1  one-cycle pulse on counted hour rollover (see Configuration).

Function
REQ-013 The prescaler SHALL count 0..CLK_FREQ-1 while time_count_en=1 and wrap to 0; internal tick SHALL be asserted in the cycle the prescaler equals CLK_FREQ-1.
REQ-014 While time_count_en=0 the prescaler SHALL be held at 0 and hour/min/sec SHALL hold.
REQ-015 On tick, sec SHALL increment by 1; sec=59 SHALL wrap to 0 and increment min.
REQ-016 On a min carry, min=59 SHALL wrap to 0 and increment hour; hour=23 SHALL wrap to 0 (23:59:59 -> 00:00:00 in one tick).
REQ-017 sec_tick SHALL be asserted in the cycle after tick, coincident with the updated sec value.
REQ-018 On load_en=1, hour<=load_hour, min<=load_min, sec<=0 and prescaler<=0 at the next edge, regardless of time_count_en.
REQ-019 Loaded hour>23 SHALL be stored as 0; loaded min>59 SHALL be stored as 0.
REQ-020 load_en SHALL take priority over a coincident tick; that tick SHALL be discarded and sec_tick/chime SHALL NOT pulse.
REQ-021 hour/min SHALL be stable registered values so the downstream-fed adjust logic sees no combinational path from load_hour/load_min.
REQ-022 Holding load_en high for N cycles SHALL reload every cycle with no counting.

Reset
REQ-023 rst=0 SHALL asynchronously force hour=0, min=0, sec=0, prescaler=0, sec_tick=0, chime=0.
REQ-024 Reset asserted mid-second or mid-load SHALL discard all pending ticks and loads; counting SHALL resume from 00:00:00 with a full CLK_FREQ-cycle first second after release.

Configuration
REQ-025 Macro HOURLY_CHIME_EN SHALL control the chime feature.
REQ-026 With HOURLY_CHIME_EN defined, chime SHALL pulse one cycle, coincident with sec_tick, when a tick takes min 59->0 and sec 59->0; loads SHALL never chime.
REQ-027 Without HOURLY_CHIME_EN, chime SHALL be constant 0 and no chime logic SHALL be synthesised.

Verification (CLK_FREQ=4)
REQ-028 Reset release, time_count_en=1, 16 cycles -> sec_tick every 4th cycle, sec=4, hour=0, min=0.
REQ-029 load_en with load_hour=23, load_min=59, then 240 cycles -> 23:59:59 reached after 236 cycles; next tick -> 00:00:00, chime=1 for one cycle (0 without macro).
REQ-030 load_en with load_hour=30, load_min=61 -> hour=0, min=0, sec=0.
REQ-031 time_count_en=0 for 20 cycles at 10:20:30 -> values unchanged, no sec_tick; re-enable -> first sec_tick 4 cycles later.
REQ-032 load_en in same cycle as tick (load 05:06) -> 05:06:00, no sec_tick, next tick 4 cycles later.
REQ-033 rst pulsed low mid-second at 12:34:56 -> immediate 00:00:00, outputs zero without waiting for clk.
